// File: rtl/wave_mode_sel_if.sv
// Key/mode bundle between the board keys, wave_mode_sel and the DDS LUT select.
// The selector sits on the slave side; the key source / mode consumer uses master.
interface wave_mode_sel_if #(
  parameter int MODE_W = 3
);
  logic              key_next;
  logic              key_prev;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;
  logic              key_busy;

  modport master (
    output key_next,
    output key_prev,
    input  mode,
    input  mode_chg,
    input  key_busy
  );

  modport slave (
    input  key_next,
    input  key_prev,
    output mode,
    output mode_chg,
    output key_busy
  );
endinterface

// File: rtl/wave_mode_sel.sv
// Two-key (next/prev) debounced waveform mode selector with wrap/saturate at the ends.
// Optional long-press auto-repeat is built only when WAVE_MODE_SEL_REPEAT_EN is defined.
module wave_mode_sel #(
  parameter int N_MODES   = 4,
  parameter int MODE_W    = 3,
  parameter int INIT_MODE = 0,
  parameter int DEB_CYC   = 20000,
  parameter int WRAP      = 1,
  parameter int HOLD_CYC  = 1000000,
  parameter int REP_CYC   = 250000
) (
  input  logic           clk,
  input  logic           rst_n,
  wave_mode_sel_if.slave sel
);

  localparam int                DEB_W     = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(N_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_INIT = MODE_W'(INIT_MODE);

  if (N_MODES < 2 || N_MODES > (1 << MODE_W)) begin : g_chk_modes
    $error("wave_mode_sel: N_MODES must be in 2..2**MODE_W");
  end
  if (INIT_MODE < 0 || INIT_MODE >= N_MODES) begin : g_chk_init
    $error("wave_mode_sel: INIT_MODE must be below N_MODES");
  end
  if (DEB_CYC < 2) begin : g_chk_deb
    $error("wave_mode_sel: DEB_CYC must be at least 2");
  end
  if (HOLD_CYC < 1 || REP_CYC < 1) begin : g_chk_rpt
    $error("wave_mode_sel: HOLD_CYC and REP_CYC must be positive");
  end

  // Saturating / wrapping step helpers; explicit end compare keeps non-power-of-2 ranges legal.
  function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
    if (m == MODE_MAX) return (WRAP != 0) ? '0 : m;
    return m + 1'b1;
  endfunction

  function automatic logic [MODE_W-1:0] mode_dec(input logic [MODE_W-1:0] m);
    if (m == '0) return (WRAP != 0) ? MODE_MAX : m;
    return m - 1'b1;
  endfunction

  // Index 0 = next key, index 1 = prev key. Level 1 = released (keys are active-low).
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       acc_q, acc_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];
  logic [1:0]       pressed;

  assign raw     = {sel.key_prev, sel.key_next};
  assign pressed = ~acc_q;

  // Stage: 2-FF synchroniser and debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      acc_q   <= 2'b11;
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < 2; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != acc_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) acc_d[k] = sync2_q[k];
        else                          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
  end

`ifdef WAVE_MODE_SEL_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} key_st_t;

  localparam int               RPT_MAX   = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int               RPT_W     = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYC - 1);
  localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REP_CYC - 1);

  logic [RPT_W-1:0] rpt_cnt_q [2];
  logic [RPT_W-1:0] rpt_cnt_d [2];
`else
  typedef enum logic {S_IDLE, S_HELD} key_st_t;
`endif

  key_st_t    st_q [2];
  key_st_t    st_d [2];
  logic [1:0] step;

  // Stage: per-key press / hold FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k] <= S_IDLE;
`ifdef WAVE_MODE_SEL_REPEAT_EN
        rpt_cnt_q[k] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st_q[k] <= st_d[k];
`ifdef WAVE_MODE_SEL_REPEAT_EN
        rpt_cnt_q[k] <= rpt_cnt_d[k];
`endif
      end
    end
  end

  always_comb begin
    step = 2'b00;
    for (int k = 0; k < 2; k++) begin
      st_d[k] = st_q[k];
`ifdef WAVE_MODE_SEL_REPEAT_EN
      rpt_cnt_d[k] = '0;
`endif
      case (st_q[k])
        S_IDLE: begin
          if (pressed[k]) begin
            st_d[k] = S_HELD;
            step[k] = 1'b1;
          end
        end
        S_HELD: begin
          if (!pressed[k]) begin
            st_d[k] = S_IDLE;
          end
`ifdef WAVE_MODE_SEL_REPEAT_EN
          else if (rpt_cnt_q[k] == HOLD_LAST) begin
            st_d[k] = S_REPEAT;
            step[k] = 1'b1;
          end else begin
            rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
          end
`endif
        end
`ifdef WAVE_MODE_SEL_REPEAT_EN
        S_REPEAT: begin
          if (!pressed[k])                    st_d[k] = S_IDLE;
          else if (rpt_cnt_q[k] == REP_LAST)  step[k] = 1'b1;
          else                                rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
        end
`endif
        default: st_d[k] = S_IDLE;
      endcase
    end
  end

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              chg_q, chg_d;

  // Stage: mode register; opposing steps in the same cycle cancel
  always_comb begin
    mode_d = mode_q;
    case (step)
      2'b01:   mode_d = mode_inc(mode_q);
      2'b10:   mode_d = mode_dec(mode_q);
      default: mode_d = mode_q;
    endcase
    chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_INIT;
      chg_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      chg_q  <= chg_d;
    end
  end

  assign sel.mode     = mode_q;
  assign sel.mode_chg = chg_q;
  assign sel.key_busy = |pressed;

endmodule

// File: tb/tb_wave_mode_sel.sv
// Scoreboard bench for wave_mode_sel: three instances (wrap N=4, saturate N=4, wrap N=3)
// share the same random key stimulus and are checked against a run-length key model.
`timescale 1ns/1ps
module tb_wave_mode_sel;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic kn    = 1'b1;
  logic kp    = 1'b1;

  wave_mode_sel_if #(.MODE_W(3)) ifa ();
  wave_mode_sel_if #(.MODE_W(3)) ifb ();
  wave_mode_sel_if #(.MODE_W(2)) ifc ();

  assign ifa.key_next = kn;
  assign ifa.key_prev = kp;
  assign ifb.key_next = kn;
  assign ifb.key_prev = kp;
  assign ifc.key_next = kn;
  assign ifc.key_prev = kp;

  wave_mode_sel #(.N_MODES(4), .MODE_W(3), .INIT_MODE(0), .DEB_CYC(DEB), .WRAP(1),
                  .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_a (.clk(clk), .rst_n(rst_n), .sel(ifa));
  wave_mode_sel #(.N_MODES(4), .MODE_W(3), .INIT_MODE(0), .DEB_CYC(DEB), .WRAP(0),
                  .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_b (.clk(clk), .rst_n(rst_n), .sel(ifb));
  wave_mode_sel #(.N_MODES(3), .MODE_W(2), .INIT_MODE(0), .DEB_CYC(DEB), .WRAP(1),
                  .HOLD_CYC(HOLD), .REP_CYC(REP)) dut_c (.clk(clk), .rst_n(rst_n), .sel(ifc));

  always #5 clk = ~clk;

  logic [2:0] m_mode [3];
  logic       m_chg  [3];
  logic       m_busy [3];
  assign m_mode[0] = ifa.mode;
  assign m_mode[1] = ifb.mode;
  assign m_mode[2] = {1'b0, ifc.mode};
  assign m_chg[0]  = ifa.mode_chg;
  assign m_chg[1]  = ifb.mode_chg;
  assign m_chg[2]  = ifc.mode_chg;
  assign m_busy[0] = ifa.key_busy;
  assign m_busy[1] = ifb.key_busy;
  assign m_busy[2] = ifc.key_busy;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {int cyc; int dut; int mode;} exp_t;
  exp_t sb[$];
  int   cyc;
  bit   macc [2];        // accepted pressed state, in the raw-sample time frame
  int   mrun [2];        // consecutive samples differing from the accepted state
  int   mpress_at [2];
  int   mode_m [3];
  int   cur [3];
  int   nmodes_m [3] = '{4, 4, 3};
  bit   wrap_m   [3] = '{1'b1, 1'b0, 1'b1};
  bit   bh0, bh1, busy_exp;

  // Model: a level is accepted after DEB equal samples; the DUT sees it 2 cycles later
  // (synchroniser) and updates mode one cycle after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      sb.delete();
      for (int k = 0; k < 2; k++) begin
        macc[k] = 1'b0; mrun[k] = 0; mpress_at[k] = 0;
      end
      for (int d = 0; d < 3; d++) begin
        mode_m[d] = 0; cur[d] = 0;
      end
      bh0 = 1'b0; bh1 = 1'b0; busy_exp = 1'b0;
    end else begin
      bit [1:0] smp;
      bit [1:0] ev;
      cyc++;
      smp = {~kp, ~kn};
      ev  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (smp[k] != macc[k]) begin
          mrun[k]++;
          if (mrun[k] == DEB) begin
            macc[k] = smp[k];
            mrun[k] = 0;
            if (smp[k]) begin
              ev[k] = 1'b1;
              mpress_at[k] = cyc;
            end
          end
        end else begin
          mrun[k] = 0;
        end
`ifdef WAVE_MODE_SEL_REPEAT_EN
        if (macc[k] && !ev[k] && (cyc - mpress_at[k]) >= HOLD &&
            ((cyc - mpress_at[k] - HOLD) % REP) == 0)
          ev[k] = 1'b1;
`endif
      end
      if (ev[0] ^ ev[1]) begin
        for (int d = 0; d < 3; d++) begin
          int nm;
          nm = mode_m[d] + (ev[0] ? 1 : -1);
          if (wrap_m[d])               nm = (nm + nmodes_m[d]) % nmodes_m[d];
          else if (nm < 0)             nm = 0;
          else if (nm >= nmodes_m[d])  nm = nmodes_m[d] - 1;
          if (nm != mode_m[d]) begin
            mode_m[d] = nm;
            sb.push_back('{cyc + 3, d, nm});
          end
        end
      end
      busy_exp = bh1;
      bh1 = bh0;
      bh0 = macc[0] | macc[1];
    end
  end

  // Monitor: pops every expected change due this cycle and compares all outputs
  always @(posedge clk) begin
    #1;
    if (rst_n && cyc > 0) begin
      bit echg [3];
      for (int d = 0; d < 3; d++) echg[d] = 1'b0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        echg[e.dut] = 1'b1;
        cur[e.dut]  = e.mode;
      end
      for (int d = 0; d < 3; d++) begin
        check($sformatf("mode_chg[%0d] cyc%0d", d, cyc), 32'(m_chg[d]), 32'(echg[d]));
        check($sformatf("mode[%0d] cyc%0d", d, cyc), 32'(m_mode[d]), 32'(cur[d]));
        check($sformatf("key_busy[%0d] cyc%0d", d, cyc), 32'(m_busy[d]), 32'(busy_exp));
      end
      check("mode_c_range", 32'(m_mode[2] < 3'd3), 32'd1);
    end
  end

  task automatic drive(input bit n, input bit p, input int cycles);
    kn = n;
    kp = p;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic press(input bit n, input bit p, input int low, input int high);
    drive(n, p, low);
    drive(1'b1, 1'b1, high);
  endtask

  task automatic check_modes(input string nm, input int a, input int b, input int c);
    check({nm, "_a"}, 32'(ifa.mode), 32'(a));
    check({nm, "_b"}, 32'(ifb.mode), 32'(b));
    check({nm, "_c"}, 32'(ifc.mode), 32'(c));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_modes("rst_mode", 0, 0, 0);
    check("rst_chg",  32'(ifa.mode_chg | ifb.mode_chg | ifc.mode_chg), 32'd0);
    check("rst_busy", 32'(ifa.key_busy | ifb.key_busy | ifc.key_busy), 32'd0);
    rst_n = 1'b1;
    drive(1, 1, 3);

    // Glitch shorter than the debounce window
    drive(0, 1, 3);
    drive(1, 1, 10);
    check_modes("glitch", 0, 0, 0);

    // Latency from the raw edge
    kn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("lat_before", 32'(ifa.mode), 32'd0);
    @(posedge clk);
    #1;
    check("lat_mode", 32'(ifa.mode), 32'd1);
    check("lat_chg",  32'(ifa.mode_chg), 32'd1);
    @(negedge clk);
    drive(0, 1, 3);
    drive(1, 1, 10);

    repeat (3) press(0, 1, 8, 8);
    check_modes("next4", 0, 3, 1);
    press(1, 0, 8, 8);
    check_modes("prev1", 3, 2, 0);

    // Both keys fall together
    drive(0, 0, 8);
    check("both_busy", 32'(ifa.key_busy), 32'd1);
    check_modes("both_mode", 3, 2, 0);
    drive(0, 0, 4);
    drive(1, 1, 10);

    // Long hold
    press(0, 1, 40, 12);
`ifdef WAVE_MODE_SEL_REPEAT_EN
    check_modes("long", 3, 3, 1);
`else
    check_modes("long", 0, 3, 1);
`endif

    // Reset pulse mid-hold, key still held afterwards
    drive(0, 1, 8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_modes("midrst_mode", 0, 0, 0);
    check("midrst_chg",  32'(ifa.mode_chg | ifb.mode_chg | ifc.mode_chg), 32'd0);
    check("midrst_busy", 32'(ifa.key_busy | ifb.key_busy | ifc.key_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 10);
    drive(1, 1, 10);
    check_modes("held_rst", 1, 1, 1);

    // Randomised key traffic including bounce, overlaps and long holds
    for (int i = 0; i < 160; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: drive(1, 1, $urandom_range(1, 10));
        4, 5:       drive(0, 1, $urandom_range(1, 14));
        6:          drive(1, 0, $urandom_range(1, 14));
        7:          drive(0, 0, $urandom_range(1, 14));
        8:          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        default:    drive(1'($urandom_range(0, 1)), 1'b0, $urandom_range(25, 60));
      endcase
    end

    drive(1, 1, 40);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
